// File: rtl/pc_stall_counter_if.sv
// Request/status bundle between the stall requesters and the PC-enable counter.
// master = requester side (control unit), slave = the counter itself.
interface pc_stall_counter_if #(
    parameter int CNT_W   = 3,
    parameter int NUM_REQ = 2
);
    // Requests are level signals with edge semantics: a 0->1 step on delayEn[i]
    // is one request carrying delayLen[i*CNT_W +: CNT_W]; there is no ready, the
    // counter always accepts or drops (reqDropped) in the cycle the edge is seen.
    logic [NUM_REQ-1:0]       delayEn;
    logic [NUM_REQ*CNT_W-1:0] delayLen;
    logic                     cancel;
    logic                     pcEn;
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         remaining;
    logic                     reqDropped;
    logic                     state_dbg;

    modport master (
        output delayEn, delayLen, cancel,
        input  pcEn, busy, done, remaining, reqDropped, state_dbg
    );

    modport slave (
        input  delayEn, delayLen, cancel,
        output pcEn, busy, done, remaining, reqDropped, state_dbg
    );
endinterface

// File: rtl/pc_stall_counter.sv
// Holds the PC enable low for a programmable number of cycles after any
// request edge, with optional retrigger/extend, cancel and status pulses.
module pc_stall_counter #(
    parameter int CNT_W   = 3,
    parameter int NUM_REQ = 2,
    parameter int RETRIG  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_stall_counter_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_REQ-1:0]   prev_en_q, prev_en_d;
    logic                 done_q, done_d;
    logic                 drop_q, drop_d;

    logic [NUM_REQ-1:0]   edge_v;
    logic [CNT_W-1:0]     l_new;
    logic [CNT_W-1:0]     dec;
    logic [CNT_W-1:0]     nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            prev_en_q <= '1;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            prev_en_q <= prev_en_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    // Largest requested length among channels that saw an edge; 0 if none did.
    always_comb begin
        edge_v = bus.delayEn & ~prev_en_q;
        l_new  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (edge_v[i] && (bus.delayLen[i*CNT_W +: CNT_W] > l_new)) begin
                l_new = bus.delayLen[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        prev_en_d = bus.delayEn;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        dec       = count_q - CNT_W'(1);
        nxt       = dec;

        case (state_q)
            IDLE: begin
                if (l_new != '0) begin
                    state_d = STALL;
                    count_d = l_new;
                end
            end
            STALL: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    count_d = '0;
                    drop_d  = (l_new != '0);
                end else begin
                    if (l_new != '0) begin
                        if (RETRIG != 0) begin
                            if (l_new > dec) nxt = l_new;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                    if (nxt == '0) begin
                        state_d = IDLE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = nxt;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign bus.pcEn       = (state_q == IDLE);
    assign bus.busy       = (state_q == STALL);
    assign bus.done       = done_q;
    assign bus.remaining  = count_q;
    assign bus.reqDropped = drop_q;
    assign bus.state_dbg  = logic'(state_q);

endmodule

// File: doc/pc_stall_counter.md
Name: pc_stall_counter

Overview:
- Synchronous, parametrised successor to the PC-enable delay block.
- Holds the program-counter enable (pcEn) low for a programmable number of clk cycles after a rising edge on any of NUM_REQ request lines.
- Supports per-request delay length, retrigger/extend mode, cancel, and status outputs.
- Sits between the control unit's stall requesters (memory, multiply, branch) and the PC register's enable.

Parameters:
- CNT_W, 3: width of delay length and internal counter; max delay 2**CNT_W-1 cycles.
- NUM_REQ, 2: number of independent stall-request channels.
- RETRIG, 1: 1 = a request while stalling extends the stall to max(remaining, new); 0 = requests while stalling are dropped.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- delayEn  in  NUM_REQ  per-channel stall request; rising edge triggers.
- delayLen  in  NUM_REQ*CNT_W  per-channel delay length; channel i at bits [i*CNT_W +: CNT_W]; sampled on the triggering edge.
- cancel  in  1  synchronous abort of the current stall.
- pcEn  out  1  PC enable; low while stalling.
- busy  out  1  high while in STALL (equals ~pcEn).
- done  out  1  one-cycle pulse when a stall completes naturally.
- remaining  out  CNT_W  current counter value.
- reqDropped  out  1  one-cycle pulse when a request edge is discarded.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, pcEn=1, busy=0, done=0, reqDropped=0, remaining=0, prevEn all ones.
  - Because prevEn resets high, a delayEn held high through reset does not trigger; a fresh 0->1 transition is required.
- Edge detect: per channel, edge[i] = delayEn[i] & ~prevEn[i]. prevEn <= delayEn every cycle.
- Simultaneous edges: the candidate length Lnew is the maximum delayLen among edged channels. Channels of equal length: any may win; the result is identical.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE:
  - An edge with Lnew>0 sampled at posedge t: state=STALL, count=Lnew, pcEn=0 from t.
  - pcEn stays low for exactly Lnew cycles and returns high at posedge t+Lnew.
  - An edge with Lnew=0 is a no-op: no stall, no done, no drop.
- State STALL, each posedge, in priority order:
  1. cancel=1: state=IDLE, count=0, pcEn=1, done=0. Any same-cycle request edge is discarded and reqDropped=1 if Lnew>0.
  2. Request edge, RETRIG=1: next = max(count-1, Lnew).
  3. Request edge, RETRIG=0: next = count-1; reqDropped=1 if Lnew>0.
  4. No edge: next = count-1.
  - If next==0: state=IDLE, pcEn=1, done=1 for one cycle. Otherwise count=next, stay in STALL.
- cancel in IDLE: no effect. Same-cycle edges in IDLE are processed normally; cancel has priority only in STALL.
- done pulses only on natural expiry, never on cancel or reset.
- Arithmetic is unsigned, CNT_W bits. The decrement never underflows because count>=1 in STALL.
- Max stall is 2**CNT_W-1 cycles per load; extension never exceeds this.
- remaining = count; it reads 0 in IDLE.

Test Plan:
- Reset with delayEn[0]=1 held, release rst, hold 5 cycles -> pcEn stays 1 (no trigger). Then drop and raise delayEn[0] with delayLen0=5 -> pcEn=0 for exactly 5 cycles, remaining 5,4,3,2,1, done=1 on the cycle pcEn returns to 1.
- Simultaneous edges, delayLen0=2 and delayLen1=6 -> 6-cycle stall. Lnew=0 on both -> no stall, done never asserts.
- RETRIG=1: start a 4-cycle stall; at cycle 2 (count=3) raise ch1 with len=7 -> count=7, total stall 2+7=9 cycles. A len=1 request mid-stall -> no extension, reqDropped=0.
- RETRIG=0: same stimulus -> stall ends after 4 cycles, reqDropped=1 for one cycle at the ch1 edge.
- cancel at count=3 of a 7-cycle stall -> pcEn=1 next edge, remaining=0, done stays 0. cancel plus same-cycle edge -> IDLE, reqDropped=1.
- Assert rst mid-stall (count=4) between clock edges -> pcEn=1 and remaining=0 immediately (async). After release, no spurious stall.
